v1_peak_detector: RTL and testbench

- Pulse-height extraction stage directly downstream of the variant-1 trapezoidal shaping filter.
- Consumes the filter's signed 16-bit output stream, one sample per clock. Finds each pulse's maximum using a threshold with hysteresis, then applies a hold-off window.
- Emits one event per pulse: amplitude, timestamp and pile-up flag, over a valid/ready handshake to the readout/histogram logic.

---
 rtl/package_settings.sv | 6 +
 rtl/v1_parameters.sv | 20 ++
 rtl/v1_peak_out_reg.sv | 48 ++++
 rtl/v1_peak_detector.sv | 137 +++++++++++++
 tb/tb_v1_peak_detector.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/package_settings.sv
// rtl/package_settings.sv - project-wide data path widths
package package_settings;

  localparam int SIZE_FILTER_DATA = 16;

endpackage

// File: rtl/v1_parameters.sv
// rtl/v1_parameters.sv - shared types and default constants for the variant-1 pulse chain
package v1_parameters;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    HOLDOFF = 2'd2
  } v1_peak_state_t;

  localparam int V1_THRESHOLD      = 100;
  localparam int V1_HYSTERESIS     = 20;
  localparam int V1_HOLDOFF_CYCLES = 16;
  localparam int V1_SIZE_TIMESTAMP = 32;

  // Counter width able to hold the hold-off load value.
  function automatic int v1_hcnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/v1_peak_out_reg.sv
// rtl/v1_peak_out_reg.sv - one-entry valid/ready event holding register with saturating drop counter
module v1_peak_out_reg #(
  parameter int SIZE_FILTER_DATA = 16,
  parameter int SIZE_TIMESTAMP   = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               emit,
  input  logic signed [SIZE_FILTER_DATA-1:0] emit_amplitude,
  input  logic        [SIZE_TIMESTAMP-1:0]   emit_time,
  input  logic                               emit_pileup,
  input  logic                               peak_ready,
  output logic                               peak_valid,
  output logic signed [SIZE_FILTER_DATA-1:0] peak_amplitude,
  output logic        [SIZE_TIMESTAMP-1:0]   peak_time,
  output logic                               peak_pileup,
  output logic        [15:0]                 drop_count
);

  logic accept;

  // A new event may replace the held one only when the consumer takes it this edge.
  assign accept = emit && (!peak_valid || peak_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_valid     <= 1'b0;
      peak_amplitude <= '0;
      peak_time      <= '0;
      peak_pileup    <= 1'b0;
      drop_count     <= '0;
    end else begin
      if (accept) begin
        peak_valid     <= 1'b1;
        peak_amplitude <= emit_amplitude;
        peak_time      <= emit_time;
        peak_pileup    <= emit_pileup;
      end else if (emit) begin
        if (drop_count != 16'hFFFF) begin
          drop_count <= drop_count + 16'd1;
        end
      end else if (peak_valid && peak_ready) begin
        peak_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/v1_peak_detector.sv
// rtl/v1_peak_detector.sv - hysteresis peak finder with hold-off; V1_PEAK_PILEUP_REJECT_EN suppresses piled-up events
module v1_peak_detector
  import v1_parameters::*;
#(
  parameter int SIZE_FILTER_DATA = package_settings::SIZE_FILTER_DATA,
  parameter int SIZE_TIMESTAMP   = V1_SIZE_TIMESTAMP,
  parameter int THRESHOLD        = V1_THRESHOLD,
  parameter int HYSTERESIS       = V1_HYSTERESIS,
  parameter int HOLDOFF_CYCLES   = V1_HOLDOFF_CYCLES
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic signed [SIZE_FILTER_DATA-1:0] filter_data,
  input  logic                               peak_ready,
  output logic                               peak_valid,
  output logic signed [SIZE_FILTER_DATA-1:0] peak_amplitude,
  output logic        [SIZE_TIMESTAMP-1:0]   peak_time,
  output logic                               peak_pileup,
  output logic        [15:0]                 drop_count
);

  localparam int CW = SIZE_FILTER_DATA + 1;
  localparam int HW = v1_hcnt_width(HOLDOFF_CYCLES);

  localparam logic signed [CW-1:0] LEVEL_HIGH = CW'(THRESHOLD);
  localparam logic signed [CW-1:0] LEVEL_LOW  = CW'(THRESHOLD - HYSTERESIS);
  localparam logic        [HW-1:0] HOLD_LOAD  = HW'(HOLDOFF_CYCLES);

  v1_peak_state_t state_q, state_d;

  logic        [SIZE_TIMESTAMP-1:0]   ts_cnt;
  logic        [SIZE_TIMESTAMP-1:0]   ts_q;
  logic signed [SIZE_FILTER_DATA-1:0] s_q;
  logic signed [SIZE_FILTER_DATA-1:0] max_q, max_d;
  logic        [SIZE_TIMESTAMP-1:0]   max_t_q, max_t_d;
  logic        [HW-1:0]               hcnt_q, hcnt_d;
  logic                               pile_q, pile_d;

  logic signed [CW-1:0] s_ext, max_ext;
  logic                 above_high, below_low, above_max;
  logic                 emit_raw, pile_final, emit, emit_pileup;

  assign s_ext      = {s_q[SIZE_FILTER_DATA-1], s_q};
  assign max_ext    = {max_q[SIZE_FILTER_DATA-1], max_q};
  assign above_high = s_ext > LEVEL_HIGH;
  assign below_low  = s_ext < LEVEL_LOW;
  assign above_max  = s_ext > max_ext;

  // The final hold-off sample also counts towards pile-up.
  assign pile_final = pile_q | above_high;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_cnt  <= '0;
      ts_q    <= '0;
      s_q     <= '0;
      state_q <= IDLE;
      max_q   <= '0;
      max_t_q <= '0;
      hcnt_q  <= '0;
      pile_q  <= 1'b0;
    end else begin
      ts_cnt  <= ts_cnt + SIZE_TIMESTAMP'(1);
      ts_q    <= ts_cnt;
      s_q     <= filter_data;
      state_q <= state_d;
      max_q   <= max_d;
      max_t_q <= max_t_d;
      hcnt_q  <= hcnt_d;
      pile_q  <= pile_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    max_d    = max_q;
    max_t_d  = max_t_q;
    hcnt_d   = hcnt_q;
    pile_d   = pile_q;
    emit_raw = 1'b0;
    case (state_q)
      IDLE: begin
        if (above_high) begin
          state_d = ARMED;
          max_d   = s_q;
          max_t_d = ts_q;
        end
      end
      ARMED: begin
        if (above_max) begin
          max_d   = s_q;
          max_t_d = ts_q;
        end else if (below_low) begin
          state_d = HOLDOFF;
          hcnt_d  = HOLD_LOAD;
          pile_d  = 1'b0;
        end
      end
      HOLDOFF: begin
        pile_d = pile_final;
        hcnt_d = hcnt_q - HW'(1);
        if (hcnt_q == HW'(1)) begin
          emit_raw = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef V1_PEAK_PILEUP_REJECT_EN
  assign emit        = emit_raw & ~pile_final;
  assign emit_pileup = 1'b0;
`else
  assign emit        = emit_raw;
  assign emit_pileup = pile_final;
`endif

  v1_peak_out_reg #(
    .SIZE_FILTER_DATA(SIZE_FILTER_DATA),
    .SIZE_TIMESTAMP  (SIZE_TIMESTAMP)
  ) u_out_reg (
    .clk           (clk),
    .reset         (reset),
    .emit          (emit),
    .emit_amplitude(max_q),
    .emit_time     (max_t_q),
    .emit_pileup   (emit_pileup),
    .peak_ready    (peak_ready),
    .peak_valid    (peak_valid),
    .peak_amplitude(peak_amplitude),
    .peak_time     (peak_time),
    .peak_pileup   (peak_pileup),
    .drop_count    (drop_count)
  );

endmodule

// File: tb/tb_v1_peak_detector.sv
// tb/tb_v1_peak_detector.sv - self-checking bench: directed pulse table, back-pressure/reset sequences, random vs model
module tb_v1_peak_detector;

  localparam int W   = 16;
  localparam int T   = 32;
  localparam int TH  = 100;
  localparam int HY  = 20;
  localparam int H   = 16;
  localparam int LOW = TH - HY;
  localparam int N   = 3000;
  localparam int PRE = 10;

`ifdef V1_PEAK_PILEUP_REJECT_EN
  localparam int PILE_EV = 0;
`else
  localparam int PILE_EV = 1;
`endif

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic signed [W-1:0] filter_data = '0;
  logic                peak_ready = 1'b0;
  logic                peak_valid;
  logic signed [W-1:0] peak_amplitude;
  logic        [T-1:0] peak_time;
  logic                peak_pileup;
  logic        [15:0]  drop_count;

  int n_cmp = 0;
  int n_bad = 0;

  v1_peak_detector #(
    .SIZE_FILTER_DATA(W),
    .SIZE_TIMESTAMP  (T),
    .THRESHOLD       (TH),
    .HYSTERESIS      (HY),
    .HOLDOFF_CYCLES  (H)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .filter_data   (filter_data),
    .peak_ready    (peak_ready),
    .peak_valid    (peak_valid),
    .peak_amplitude(peak_amplitude),
    .peak_time     (peak_time),
    .peak_pileup   (peak_pileup),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int d, input bit r);
    filter_data = 16'(d);
    peak_ready  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    filter_data = '0;
    peak_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic pulse(input int amp, input bit r);
    step(0, r);
    step(amp, r);
    step(50, r);
    repeat (20) step(0, r);
  endtask

  typedef struct {
    string        name;
    logic [127:0] s;
    int           n_events;
    int           amp;
    int           t;
    int           pile;
    int           exit_idx;
  } vec_t;

  function automatic logic [127:0] pk(input int a0, input int a1, input int a2, input int a3,
                                      input int a4, input int a5, input int a6, input int a7);
    logic [127:0] r;
    r[15:0]    = 16'(a0);
    r[31:16]   = 16'(a1);
    r[47:32]   = 16'(a2);
    r[63:48]   = 16'(a3);
    r[79:64]   = 16'(a4);
    r[95:80]   = 16'(a5);
    r[111:96]  = 16'(a6);
    r[127:112] = 16'(a7);
    return r;
  endfunction

  vec_t tab[8];

  int          d_arr [N];
  bit          r_arr [N];
  bit          em    [N];
  int          e_amp [N];
  int          e_t   [N];
  bit          e_pile[N];

  initial begin
    // Samples start PRE edges after reset, so sample index p carries timestamp PRE+p.
    tab[0] = '{"idle",         pk(0, 0, 0, 0, 0, 0, 0, 0),                  0,     0,     0,  0, 0};
    tab[1] = '{"single",       pk(0, 150, 300, 200, 70, 0, 0, 0),           1,     300,   12, 0, 4};
    tab[2] = '{"hysteresis",   pk(0, 120, 90, 130, 60, 0, 0, 0),            1,     130,   13, 0, 4};
    tab[3] = '{"equal_peaks",  pk(0, 200, 250, 250, 0, 0, 0, 0),            1,     250,   12, 0, 4};
    tab[4] = '{"at_threshold", pk(0, 100, 100, 100, 0, 0, 0, 0),            0,     0,     0,  0, 0};
    tab[5] = '{"low_edge",     pk(0, 101, 80, 80, 79, 0, 0, 0),             1,     101,   11, 0, 4};
    tab[6] = '{"extremes",     pk(-32768, 32767, -32768, 0, 0, 0, 0, 0),    1,     32767, 11, 0, 2};
    tab[7] = '{"pileup",       pk(0, 200, 50, 0, 0, 0, 0, 200),             PILE_EV, 200, 11, 1, 2};

    for (int v = 0; v < 8; v++) begin
      int                  events;
      int                  first_edge;
      int                  got_amp;
      longint              got_t;
      int                  got_pile;
      bit                  prev;
      logic signed [15:0]  sv;
      do_reset();
      chk({tab[v].name, " reset valid"}, peak_valid, 0);
      chk({tab[v].name, " reset drop"}, drop_count, 0);
      events = 0; first_edge = -1; got_amp = 0; got_t = 0; got_pile = 0; prev = 1'b0;
      for (int c = 0; c < 60; c++) begin
        int d;
        d = 0;
        if (c >= PRE && c < PRE + 8) begin
          sv = tab[v].s[16*(c-PRE) +: 16];
          d  = sv;
        end
        step(d, 1'b1);
        if (peak_valid && !prev) begin
          events++;
          if (first_edge < 0) begin
            first_edge = c;
            got_amp    = peak_amplitude;
            got_t      = peak_time;
            got_pile   = peak_pileup;
          end
        end
        prev = peak_valid;
      end
      chk({tab[v].name, " events"}, events, tab[v].n_events);
      chk({tab[v].name, " drop"}, drop_count, 0);
      if (tab[v].n_events > 0) begin
        chk({tab[v].name, " amplitude"}, got_amp, tab[v].amp);
        chk({tab[v].name, " time"}, got_t, tab[v].t);
        chk({tab[v].name, " pileup"}, got_pile, tab[v].pile);
        chk({tab[v].name, " latency"}, first_edge, PRE + tab[v].exit_idx + H + 1);
      end
    end

    // Back-pressure across three pulses: first event held, two dropped.
    do_reset();
    pulse(200, 1'b0);
    chk("bp first valid", peak_valid, 1);
    chk("bp first amp", peak_amplitude, 200);
    chk("bp first time", peak_time, 1);
    pulse(300, 1'b0);
    chk("bp hold amp", peak_amplitude, 200);
    chk("bp hold time", peak_time, 1);
    chk("bp drop1", drop_count, 1);
    pulse(400, 1'b0);
    chk("bp hold valid", peak_valid, 1);
    chk("bp hold amp2", peak_amplitude, 200);
    chk("bp drop2", drop_count, 2);
    step(0, 1'b1);
    chk("bp release valid", peak_valid, 0);
    chk("bp release drop", drop_count, 2);

    // Asynchronous reset mid-cycle while ARMED with a held event and a drop.
    do_reset();
    pulse(200, 1'b0);
    pulse(220, 1'b0);
    step(0, 1'b0);
    step(250, 1'b0);
    step(240, 1'b0);
    chk("ar pre valid", peak_valid, 1);
    chk("ar pre drop", drop_count, 1);
    #3;
    reset = 1'b0;
    #1;
    chk("ar valid", peak_valid, 0);
    chk("ar amp", peak_amplitude, 0);
    chk("ar time", peak_time, 0);
    chk("ar pileup", peak_pileup, 0);
    chk("ar drop", drop_count, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    begin
      int     got_amp;
      longint got_t;
      bit     seen;
      seen = 1'b0; got_amp = 0; got_t = 0;
      step(0, 1'b1);
      step(180, 1'b1);
      step(50, 1'b1);
      for (int c = 0; c < 25; c++) begin
        step(0, 1'b1);
        if (peak_valid && !seen) begin
          seen    = 1'b1;
          got_amp = peak_amplitude;
          got_t   = peak_time;
        end
      end
      chk("ar next seen", seen, 1);
      chk("ar next amp", got_amp, 180);
      chk("ar next time", got_t, 1);
    end

    // Random stream: segments of low / marginal / high / extreme samples and ready bursts.
    begin
      int c;
      c = 0;
      while (c < N) begin
        int len, cls;
        len = $urandom_range(1, 20);
        cls = $urandom_range(0, 9);
        for (int k = 0; k < len && c < N; k++) begin
          if (cls < 5)      d_arr[c] = int'($urandom_range(0, 379)) - 300;
          else if (cls < 7) d_arr[c] = int'($urandom_range(80, 100));
          else if (cls < 9) d_arr[c] = int'($urandom_range(101, 2000));
          else              d_arr[c] = ($urandom_range(0, 1) == 0) ? -32768 : 32767;
          c++;
        end
      end
      c = 0;
      while (c < N) begin
        int len;
        bit rv;
        len = $urandom_range(1, 60);
        rv  = ($urandom_range(0, 1) == 1);
        for (int k = 0; k < len && c < N; k++) begin
          r_arr[c] = rv;
          c++;
        end
      end
    end

    // Event list from the pulse rules: sample i is registered at edge i and timestamped i.
    for (int i = 0; i < N; i++) begin
      em[i] = 1'b0; e_amp[i] = 0; e_t[i] = 0; e_pile[i] = 1'b0;
    end
    begin
      int i;
      i = 0;
      while (i < N) begin
        if (d_arr[i] > TH) begin
          int mx, t, j;
          bit pile;
          mx = d_arr[i]; t = i; j = i + 1;
          while (j < N && d_arr[j] >= LOW) begin
            if (d_arr[j] > mx) begin mx = d_arr[j]; t = j; end
            j++;
          end
          if (j >= N) break;
          pile = 1'b0;
          for (int k = j + 1; k <= j + H && k < N; k++) if (d_arr[k] > TH) pile = 1'b1;
          if (j + H + 1 < N) begin
`ifdef V1_PEAK_PILEUP_REJECT_EN
            if (!pile) begin
              em[j+H+1] = 1'b1; e_amp[j+H+1] = mx; e_t[j+H+1] = t; e_pile[j+H+1] = 1'b0;
            end
`else
            em[j+H+1] = 1'b1; e_amp[j+H+1] = mx; e_t[j+H+1] = t; e_pile[j+H+1] = pile;
`endif
          end
          i = j + H + 1;
        end else begin
          i++;
        end
      end
    end

    do_reset();
    begin
      bit mv, mp;
      int ma, mt, mdrop;
      mv = 1'b0; mp = 1'b0; ma = 0; mt = 0; mdrop = 0;
      for (int c = 0; c < N; c++) begin
        step(d_arr[c], r_arr[c]);
        if (em[c]) begin
          if (!mv || r_arr[c]) begin
            mv = 1'b1; ma = e_amp[c]; mt = e_t[c]; mp = e_pile[c];
          end else if (mdrop < 65535) begin
            mdrop++;
          end
        end else if (mv && r_arr[c]) begin
          mv = 1'b0;
        end
        chk($sformatf("rnd valid @%0d", c), peak_valid, mv);
        chk($sformatf("rnd drop @%0d", c), drop_count, mdrop);
        if (mv) begin
          chk($sformatf("rnd amp @%0d", c), peak_amplitude, ma);
          chk($sformatf("rnd time @%0d", c), peak_time, mt);
          chk($sformatf("rnd pileup @%0d", c), peak_pileup, mp);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
